// File: rtl/ppu_pkg.sv
// Shared PPU definitions: bus widths, the irq-clear address, write-scheduler
// FSM states and the buffered CPU write record.
package ppu_pkg;

    localparam int unsigned PPU_ADDR_W = 12;
    localparam int unsigned PPU_DATA_W = 32;

    // Writes to this word address clear the frame irq and are never buffered.
    localparam logic [PPU_ADDR_W-1:0] IRQ_CLR_ADDR = 12'hFFF;

    typedef enum logic [1:0] {
        WS_ACTIVE,
        WS_DRAIN,
        WS_DONE
    } ws_state_t;

    typedef struct packed {
        logic [PPU_ADDR_W-1:0] addr;
        logic [PPU_DATA_W-1:0] data;
    } cpu_wr_t;

endpackage

// File: rtl/ppu_sync_fifo.sv
// Synchronous FIFO with a combinational head read.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   push, wdata   enqueue wdata (caller only pushes when !full or popping)
//   pop, rdata    dequeue; rdata always shows the head entry
//   full, empty   occupancy flags derived from count
//   count         number of stored entries, 0..DEPTH
module ppu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointer increments wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/ppu_write_scheduler.sv
// Buffers CPU bus writes to PPU memories and commits them only during vblank,
// so the CPU cannot tear tile/sprite/OAM/palette data mid-frame. Raises the
// frame irq at the start of each vblank.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   chipselect, write   Avalon slave select and write strobe
//   address, write_data Avalon word address and write data
//   vblank              high during vertical blanking
//   waitrequest         high while the FIFO is full
//   wr_valid            one-cycle commit strobe toward addr_decode
//   wr_addr, wr_data    commit address/data, held between commits
//   irq                 frame interrupt (level)
//   overflow            sticky: a write was dropped because the FIFO was full
module ppu_write_scheduler #(
    parameter int unsigned       DEPTH        = 16,
    parameter int unsigned       ADDR_W       = ppu_pkg::PPU_ADDR_W,
    parameter int unsigned       DATA_W       = ppu_pkg::PPU_DATA_W,
    parameter logic [ADDR_W-1:0] IRQ_CLR_ADDR = ppu_pkg::IRQ_CLR_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              vblank,
    output logic              waitrequest,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              irq,
    output logic              overflow
);

    import ppu_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    ws_state_t         state_q, state_d;
    logic              vblank_q;
    logic              irq_q, irq_d;
    logic              overflow_q, overflow_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    cpu_wr_t          push_entry, head_entry;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             wr_cmd, is_clr, vblank_rise, push, pop, drop;

    assign wr_cmd      = chipselect & write;
    assign is_clr      = (address == IRQ_CLR_ADDR);
    assign vblank_rise = vblank & ~vblank_q;
    assign pop         = (state_q == WS_DRAIN) & vblank & ~fifo_empty;
    // A simultaneous pop frees the slot, so a push is legal even when full.
    assign push        = wr_cmd & ~is_clr & (~fifo_full | pop);
    assign drop        = wr_cmd & ~is_clr & fifo_full & ~pop;

    assign push_entry.addr = address;
    assign push_entry.data = write_data;

    ppu_sync_fifo #(
        .WIDTH ($bits(cpu_wr_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WS_ACTIVE: begin
                if (vblank_rise) begin
                    state_d = WS_DRAIN;
                end
            end
            WS_DRAIN: begin
                if (!vblank) begin
                    state_d = WS_ACTIVE;
                end else if (fifo_empty ||
                             (pop && !push && fifo_count == CNT_W'(1))) begin
                    state_d = WS_DONE;
                end
            end
            WS_DONE: begin
                if (!vblank) begin
                    state_d = WS_ACTIVE;
                end else if (!fifo_empty) begin
                    state_d = WS_DRAIN;
                end
            end
            default: state_d = WS_ACTIVE;
        endcase
    end

    always_comb begin
        // vblank start outranks a same-cycle clear so a new frame is never missed.
        irq_d = irq_q;
        if (vblank_rise) begin
            irq_d = 1'b1;
        end else if (wr_cmd && is_clr) begin
            irq_d = 1'b0;
        end
        overflow_d = overflow_q | drop;
        wr_valid_d = pop;
        wr_addr_d  = pop ? head_entry.addr : wr_addr_q;
        wr_data_d  = pop ? head_entry.data : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WS_ACTIVE;
            vblank_q   <= 1'b0;
            irq_q      <= 1'b0;
            overflow_q <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            vblank_q   <= vblank;
            irq_q      <= irq_d;
            overflow_q <= overflow_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign waitrequest = fifo_full;
    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign irq         = irq_q;
    assign overflow    = overflow_q;

endmodule
